sev_seg_decode: RTL
===================

# sev_seg_decode

Receive-side counterpart of the `sev_seg` display driver. This block monitors a multiplexed, active-low 7-segment bus (segment lines plus 4 digit enables) and waits for each digit slot to settle. It then decodes the segment pattern back to a hex nibble and keeps a per-slot digit register. It sits on board-loopback and display-monitor paths, so self-test logic can read back what the driver is showing.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a capture; legal range 2..255.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: synchronous, active-high reset.
- `seg_in  in  8`: segment lines, active-low; bit0=a … bit6=g, bit7=dp.
- `an_in  in  4`: digit enables, active-low; bit i selects slot i.
- `digits  out  16`: slot i nibble at `[4i+3:4i]`.
- `dp  out  4`: decimal point per slot, 1 = lit.
- `digit_vld  out  4`: slot i has held a valid capture since reset.
- `upd  out  1`: one-cycle pulse when a slot is written.
- `upd_idx  out  2`: slot written; valid while `upd` is high.
- `err  out  1`: one-cycle pulse when a capture fails.
- `err_cnt  out  8`: capture-error count, saturates at 255.

## Operation
- **Sampling.** `{seg_in, an_in}` are registered every cycle. Pattern bits are inverted to active-high before decoding.
- **Stability counter `stab_cnt`.**
  - Reset to 0 when the current sample differs from the previous one.
  - Otherwise increments, saturating at `STABLE_CYCLES-1`.
- **FSM states.**
  - SETTLE: counting. Moves to DECODE when `stab_cnt` reaches `STABLE_CYCLES-1`.
  - DECODE: one cycle. Evaluates the sample and goes to HOLD.
  - HOLD: waits. Any sample change returns to SETTLE.
  - Exactly one evaluation per stable window.
- **DECODE rules** (after inverting `an_in`):
  - Exactly one enable active, pattern in table: write `digits[slot]`, `dp[slot]`, set `digit_vld[slot]`, pulse `upd` with `upd_idx`=slot.
  - Exactly one enable active, pattern not in table: pulse `err`, increment `err_cnt` (saturating), leave the slot unchanged.
  - More than one enable active: treated as an error; no slot is written.
  - No enable active (blanking): no action, no error.
- **Decode table** (gfedcba, active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other value is invalid. dp is ignored for table lookup.
- **Simultaneous events.** A sample change during DECODE does not cancel the write in progress. The FSM then re-enters SETTLE.
- **Rewrite.** A slot whose `digit_vld` is already set is overwritten by any later valid capture.

## Timing
- **Reset values.** `digits`=0, `dp`=0, `digit_vld`=0, `upd`=0, `upd_idx`=0, `err`=0, `err_cnt`=0. Sample registers reset to 0xFF/0xF (all inactive), `stab_cnt`=0, FSM=SETTLE.
- **Latency.**
  - Without sync: a new stable input first sampled at edge 0 gives `upd`/`err` and updated outputs after edge `STABLE_CYCLES`. This is `STABLE_CYCLES+1` edges from the input change; 5 at the default.
  - With sync: add 2 edges.
- **Pulse width.** `upd` and `err` are high for exactly one cycle, and are never high together.
- **Reset mid-operation.** `rst` during SETTLE/DECODE/HOLD aborts without a write, clears all state and counters on that edge, and counting restarts on the first edge after `rst` falls.
- **Short glitches.** A pattern held for fewer than `STABLE_CYCLES` samples produces no output activity.

## Configuration
- `SEV_SEG_DECODE_SYNC_EN` defined: a two-flop synchronizer is placed on `seg_in`/`an_in` ahead of the sample register. Latency grows by 2 cycles. Synchronizer flops reset to inactive.
- Not defined: inputs go straight to the sample register, for same-clock-domain loopback only.

## Structure
- Package `sev_seg_pkg` holds:
  - the 16 segment-pattern constants;
  - the FSM state enum (SETTLE/DECODE/HOLD);
  - slot-count constant `SEV_SEG_DIGITS`=4.
- The encoder should share these pattern constants.
- Sub-module `sev_seg_lut`: combinational 7-bit pattern in, 4-bit nibble plus `hit` flag out. It is reused by the encoder's self-check.

## Test plan
- **Valid capture.** Reset, then hold `an_in`=1110, `seg_in`=~8'h5B (digit 2, dp off) for 10 cycles. Expect one `upd` with `upd_idx`=0 at edge 5, `digits[3:0]`=2, `digit_vld`=0001.
- **Full scan.** Scan slots 0..3 with 2, 6, b, E, dp on slot 3, 8 cycles per slot. Expect `digits`=16'hEB62, `dp`=1000, `digit_vld`=1111, and 4 `upd` pulses.
- **Glitch rejection.** Hold a pattern for 3 cycles with `STABLE_CYCLES`=4. Expect no `upd` and no `err`.
- **Invalid inputs.**
  - Pattern 7'h00 on slot 1: one `err` pulse, `err_cnt`=1, slot 1 unchanged.
  - `an_in`=1100: `err` pulse, no write.
  - `an_in`=1111: no pulse.
- **Saturation.** 300 invalid captures give `err_cnt`=255.
- **Reset mid-operation.** Assert `rst` at `stab_cnt`=2. Expect all outputs at reset values, and the next capture needs a full `STABLE_CYCLES` window after release.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared definitions for the sev_seg display driver and its receive-side decoder:
// segment patterns, FSM state encoding and slot count.
package sev_seg_pkg;

  localparam int unsigned SEV_SEG_DIGITS = 4;

  // Active-high gfedcba patterns, shared with the encoder.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    StSettle,
    StDecode,
    StHold
  } state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

  // Index of the highest set bit; only meaningful for one-hot input.
  function automatic logic [1:0] onehot_to_idx(input logic [SEV_SEG_DIGITS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < SEV_SEG_DIGITS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sev_seg_lut.sv
// Segment pattern to hex nibble lookup; hit is low for patterns outside the table.
module sev_seg_lut
  import sev_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/sev_seg_decode.sv
// Monitors a multiplexed active-low 7-segment bus and rebuilds per-slot digit registers.
// Define SEV_SEG_DECODE_SYNC_EN to add a two-flop input synchronizer.
module sev_seg_decode
  import sev_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  seg_in,
  input  logic [SEV_SEG_DIGITS-1:0]   an_in,
  output logic [4*SEV_SEG_DIGITS-1:0] digits,
  output logic [SEV_SEG_DIGITS-1:0]   dp,
  output logic [SEV_SEG_DIGITS-1:0]   digit_vld,
  output logic                        upd,
  output logic [1:0]                  upd_idx,
  output logic                        err,
  output logic [7:0]                  err_cnt
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);
  localparam int unsigned SW = 8 + SEV_SEG_DIGITS;
  localparam logic [SW-1:0] IDLE_BUS = '1;

  logic [SW-1:0] bus_src;

`ifdef SEV_SEG_DECODE_SYNC_EN
  logic [SW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_BUS;
      sync2_q <= IDLE_BUS;
    end else begin
      sync1_q <= {seg_in, an_in};
      sync2_q <= sync1_q;
    end
  end

  assign bus_src = sync2_q;
`else
  assign bus_src = {seg_in, an_in};
`endif

  logic [SW-1:0] samp_q;
  logic [7:0]    stab_q, stab_d;
  state_e        state_q, state_d;
  logic          changed;

  assign changed = (bus_src != samp_q);

  always_comb begin
    stab_d = stab_q;
    if (changed) begin
      stab_d = 8'd0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 8'd1;
    end
  end

  // Entering DECODE on the edge the count reaches its limit keeps the
  // capture latency at STABLE_CYCLES edges after the first sample.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSettle: if (stab_d == STAB_MAX) state_d = StDecode;
      StDecode: state_d = changed ? StSettle : StHold;
      StHold:   if (changed) state_d = StSettle;
      default:  state_d = StSettle;
    endcase
  end

  // Decode path works on the registered sample, active-high.
  logic [SEV_SEG_DIGITS-1:0] an_act;
  logic [6:0]                pat;
  logic                      dp_bit;
  logic [3:0]                nibble;
  logic                      hit;
  logic                      one_hot, multi;
  logic                      do_write, do_err;
  logic [1:0]                slot;

  assign an_act = ~samp_q[SEV_SEG_DIGITS-1:0];
  assign pat    = ~samp_q[SW-2:SEV_SEG_DIGITS];
  assign dp_bit = ~samp_q[SW-1];

  sev_seg_lut u_lut (
    .pattern (pat),
    .nibble  (nibble),
    .hit     (hit)
  );

  assign one_hot  = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
  assign multi    = (an_act != '0) && !one_hot;
  assign do_write = (state_q == StDecode) && one_hot && hit;
  assign do_err   = (state_q == StDecode) && (multi || (one_hot && !hit));
  assign slot     = onehot_to_idx(an_act);

  logic [4*SEV_SEG_DIGITS-1:0] digits_q, digits_d;
  logic [SEV_SEG_DIGITS-1:0]   dp_q, dp_d;
  logic [SEV_SEG_DIGITS-1:0]   vld_q, vld_d;
  logic                        upd_q, err_q;
  logic [1:0]                  upd_idx_q, upd_idx_d;
  logic [7:0]                  err_cnt_q, err_cnt_d;

  always_comb begin
    digits_d  = digits_q;
    dp_d      = dp_q;
    vld_d     = vld_q;
    upd_idx_d = upd_idx_q;
    err_cnt_d = err_cnt_q;
    if (do_write) begin
      upd_idx_d = slot;
      for (int i = 0; i < SEV_SEG_DIGITS; i++) begin
        if (an_act[i]) begin
          digits_d[4*i +: 4] = nibble;
          dp_d[i]            = dp_bit;
          vld_d[i]           = 1'b1;
        end
      end
    end
    if (do_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q    <= IDLE_BUS;
      stab_q    <= 8'd0;
      state_q   <= StSettle;
      digits_q  <= '0;
      dp_q      <= '0;
      vld_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 2'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      samp_q    <= bus_src;
      stab_q    <= stab_d;
      state_q   <= state_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      vld_q     <= vld_d;
      upd_q     <= do_write;
      upd_idx_q <= upd_idx_d;
      err_q     <= do_err;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign digits    = digits_q;
  assign dp        = dp_q;
  assign digit_vld = vld_q;
  assign upd       = upd_q;
  assign upd_idx   = upd_idx_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule
